// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

  // Bit period in system clocks; truncating division, caller guarantees >= 2.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// 8N1 frame serialiser: FSM, baud counter and shift register with load/ready handshake.
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 busy,
  output logic                 tx,
  output logic                 done
);

  localparam int unsigned BW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] LAST    = BW'(DIV - 1);
  localparam logic [BW-1:0] DONE_AT = BW'(DIV - 2);

  tx_state_t            state;
  logic [BW-1:0]        baud;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      done    <= 1'b0;
    end else begin
      // Registered one cycle early so the pulse lands on the last stop cycle.
      done <= (state == STOP) && (baud == DONE_AT);
      unique case (state)
        IDLE: begin
          baud <= '0;
          if (load) begin
            shreg   <= data;
            bit_idx <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud == LAST) begin
            baud  <= '0;
            tx    <= shreg[0];
            state <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud == LAST) begin
            baud <= '0;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud == LAST) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte FIFO from the CPU store path feeding the frame serialiser.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     clr_ovf,
  output logic                     UART_TX,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     tx_busy,
  output logic                     tx_done,
  output logic                     overflow
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          ready;

  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  // Full test uses the pre-edge count, so a push while full drops even if a pop coincides.
  assign push = wr_en && !fifo_full;
  assign pop  = ready && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && fifo_full) overflow <= 1'b1;
      else if (clr_ovf)       overflow <= 1'b0;
    end
  end

  uart_tx_shifter #(.DIV(DIV)) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (pop),
    .data  (mem[rd_ptr]),
    .ready (ready),
    .busy  (tx_busy),
    .tx    (UART_TX),
    .done  (tx_done)
  );

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl against a queue-and-arithmetic frame model.
module tb_uart_tx_ctrl;

  localparam int unsigned CLK_FREQ = 8;
  localparam int unsigned BAUD     = 1;
  localparam int unsigned DEPTH    = 4;
  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       reset, wr_en, clr_ovf;
  logic [7:0] wr_data;
  logic       line, fifo_full, fifo_empty, tx_busy, tx_done, overflow;
  logic [2:0] count;

  uart_tx_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .UART_TX(line), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .count(count),
    .tx_busy(tx_busy), .tx_done(tx_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: queued bytes, current frame start cycle/byte, first cycle the line is free.
  int          cyc;
  logic [7:0]  mq[$];
  logic        m_ovf;
  int          f_start;
  logic [7:0]  f_byte;
  int          next_idle;
  logic        e_tx, e_busy, e_done;
  int          e_count;

  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    f_start = -1;
    next_idle = 0;
  endtask

  task automatic model_eval();
    int  rel;
    logic inf;
    rel = cyc - f_start;
    inf = (f_start >= 0) && (rel >= 0) && (rel < FRAME);
    e_tx    = inf ? frame_bit(f_byte, rel / DIV) : 1'b1;
    e_busy  = inf;
    e_done  = inf && (rel == FRAME - 1);
    e_count = mq.size();
  endtask

  task automatic model_step(input logic wr, input logic [7:0] d, input logic clr);
    logic pu, po;
    po = (cyc >= next_idle) && (mq.size() > 0);
    pu = wr && (mq.size() < DEPTH);
    if (po) begin
      f_byte = mq.pop_front();
      f_start = cyc + 1;
      next_idle = cyc + 1 + FRAME;
    end
    if (pu) mq.push_back(d);
    if (wr && !pu) m_ovf = 1'b1;
    else if (clr)  m_ovf = 1'b0;
    cyc++;
  endtask

  task automatic drive(input logic wr, input logic [7:0] d, input logic clr);
    wr_en = wr; wr_data = d; clr_ovf = clr;
    model_step(wr, d, clr);
    @(negedge clk);
    wr_en = 1'b0; clr_ovf = 1'b0;
  endtask

  function automatic logic model_idle();
    return (mq.size() == 0) && (cyc >= next_idle);
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({line, count, fifo_empty, fifo_full, tx_busy, tx_done, overflow} !== {1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0})
      begin errors++; $display("FAIL reset_state got %b want 1000100000", {line, count, fifo_empty, fifo_full, tx_busy, tx_done, overflow}); end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    for (int i = 0; i <= 84; i++) begin
      model_eval();
      checks++;
      if ({line, tx_busy, tx_done, count} !== {e_tx, e_busy, e_done, 3'(e_count)})
        begin errors++; $display("FAIL single c%0d {tx,busy,done,count} got %b want %b", i, {line, tx_busy, tx_done, count}, {e_tx, e_busy, e_done, 3'(e_count)}); end
      if (i == 2)  begin checks++; if (line !== 1'b0)    begin errors++; $display("FAIL single_start got %b want 0", line); end end
      if (i == 81) begin checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL single_done81 got %b want 1", tx_done); end end
      if (i == 82) begin checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy82 got %b want 0", tx_busy); end end
      drive(i == 0, 8'hA5, 1'b0);
    end
  endtask

  task automatic test_burst(input int n);
    bit finished = 0;
    int peak = 0, e_peak = 0;
    for (int i = 0; i < 3000; i++) begin
      model_eval();
      if (int'(count) > peak) peak = int'(count);
      if (e_count > e_peak) e_peak = e_count;
      checks++;
      if ({line, count, fifo_full, fifo_empty, overflow} !== {e_tx, 3'(e_count), e_count == DEPTH, e_count == 0, m_ovf})
        begin errors++; $display("FAIL burst%0d c%0d {tx,count,full,empty,ovf} got %b want %b", n, i,
          {line, count, fifo_full, fifo_empty, overflow}, {e_tx, 3'(e_count), e_count == DEPTH, e_count == 0, m_ovf}); end
      if (i == n + 1) begin
        checks++;
        if (overflow !== (n > DEPTH + 1)) begin errors++; $display("FAIL burst%0d_ovf got %b want %b", n, overflow, n > DEPTH + 1); end
      end
      if (i > n && model_idle()) begin finished = 1; break; end
      drive(i < n, 8'($urandom), 1'b0);
    end
    checks++;
    if (!finished) begin errors++; $display("FAIL burst%0d_timeout got busy want idle", n); end
    checks++;
    if (peak !== e_peak) begin errors++; $display("FAIL burst%0d_peak got %0d want %0d", n, peak, e_peak); end
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL burst%0d_clr got %b want 0", n, overflow); end
  endtask

  task automatic test_overflow_clear();
    bit finished = 0;
    for (int i = 0; i < 3000; i++) begin
      model_eval();
      checks++;
      if ({overflow, count, line} !== {m_ovf, 3'(e_count), e_tx})
        begin errors++; $display("FAIL ovfclr c%0d {ovf,count,tx} got %b want %b", i, {overflow, count, line}, {m_ovf, 3'(e_count), e_tx}); end
      if (i == 5) begin checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovfclr_full got %b want 1", fifo_full); end end
      if (i == 6) begin checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovfclr_setwins got %b want 1", overflow); end end
      if (i == 7) begin checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovfclr_clear got %b want 0", overflow); end end
      if (i > 7 && model_idle()) begin finished = 1; break; end
      drive(i <= 5, 8'($urandom), i == 5 || i == 6);
    end
    checks++;
    if (!finished) begin errors++; $display("FAIL ovfclr_timeout got busy want idle"); end
  endtask

  task automatic test_back_to_back();
    int falls[$];
    logic prev = 1'b1;
    bit finished = 0;
    for (int i = 0; i < 1000; i++) begin
      model_eval();
      checks++;
      if (line !== e_tx) begin errors++; $display("FAIL b2b_line c%0d got %b want %b", i, line, e_tx); end
      if (prev === 1'b1 && line === 1'b0) falls.push_back(i);
      prev = line;
      if (i > 2 && model_idle()) begin finished = 1; break; end
      drive(i < 2, (i == 0) ? 8'h00 : 8'hFF, 1'b0);
    end
    checks++;
    if (!finished || falls.size() != 2) begin errors++; $display("FAIL b2b_falls got %0d want 2", falls.size()); end
    else begin
      checks++;
      if (falls[1] - falls[0] != FRAME + 1) begin errors++; $display("FAIL b2b_gap got %0d want %0d", falls[1] - falls[0], FRAME + 1); end
    end
  endtask

  task automatic test_reset_mid();
    bit finished = 0;
    for (int i = 0; i <= 40; i++) begin
      model_eval();
      checks++;
      if ({line, tx_busy, count} !== {e_tx, e_busy, 3'(e_count)})
        begin errors++; $display("FAIL rstmid c%0d {tx,busy,count} got %b want %b", i, {line, tx_busy, count}, {e_tx, e_busy, 3'(e_count)}); end
      if (i == 40) break;
      drive(i < 3, 8'($urandom), 1'b0);
    end
    checks++;
    if (count !== 3'd2) begin errors++; $display("FAIL rstmid_queued got %0d want 2", count); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({line, count, tx_busy, fifo_empty} !== {1'b1, 3'd0, 1'b0, 1'b1})
      begin errors++; $display("FAIL rstmid_async {tx,count,busy,empty} got %b want 100001", {line, count, tx_busy, fifo_empty}); end
    @(negedge clk);
    cyc++;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 200; i++) begin
      model_eval();
      checks++;
      if ({line, tx_busy, tx_done} !== {e_tx, e_busy, e_done})
        begin errors++; $display("FAIL rstmid_after c%0d {tx,busy,done} got %b want %b", i, {line, tx_busy, tx_done}, {e_tx, e_busy, e_done}); end
      if (i > 0 && model_idle()) begin finished = 1; break; end
      drive(i == 0, 8'h3C, 1'b0);
    end
    checks++;
    if (!finished) begin errors++; $display("FAIL rstmid_timeout got busy want idle"); end
  endtask

  task automatic test_wrap();
    logic [7:0] sent[$];
    logic [7:0] got[$];
    logic [7:0] base, dec_b;
    logic prev = 1'b1;
    int dec_t = -1;
    bit finished;
    base = 8'($urandom);
    for (int r = 0; r < 3; r++) begin
      finished = 0;
      for (int i = 0; i < 2000; i++) begin
        model_eval();
        checks++;
        if (line !== e_tx) begin errors++; $display("FAIL wrap_line r%0d c%0d got %b want %b", r, i, line, e_tx); end
        if (dec_t < 0) begin
          if (prev === 1'b1 && line === 1'b0) dec_t = 0;
        end else begin
          dec_t++;
          if ((dec_t % DIV) == DIV / 2 && dec_t / DIV >= 1 && dec_t / DIV <= 8) dec_b[dec_t / DIV - 1] = line;
          if (dec_t == 9 * DIV + DIV / 2) begin got.push_back(dec_b); dec_t = -1; end
        end
        prev = line;
        if (i > 4 && model_idle()) begin finished = 1; break; end
        if (i < 4) begin
          sent.push_back(base + 8'(17 * sent.size()));
          drive(1'b1, sent[sent.size() - 1], 1'b0);
        end else begin
          drive(1'b0, 8'h00, 1'b0);
        end
      end
      checks++;
      if (!finished) begin errors++; $display("FAIL wrap_timeout r%0d got busy want idle", r); end
    end
    checks++;
    if (got.size() != 12) begin errors++; $display("FAIL wrap_count got %0d want 12", got.size()); end
    for (int k = 0; k < 12 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== sent[k]) begin errors++; $display("FAIL wrap_order #%0d got %h want %h", k, got[k], sent[k]); end
    end
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
    cyc = 0;
    model_reset();
    test_reset();
    test_single();
    test_burst(5);
    test_burst(6);
    test_overflow_clear();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
